sys_mem_s2_arbiter: RTL and testbench
=====================================

# sys_mem_s2_arbiter

Two-master arbiter and sequencer for port s2 of the 8000 x 32-bit dual-port system memory. Lets two datapath masters share the single s2 port: the SHA-1 message loader (m0) and the digest writer (m1). It provides round-robin arbitration, optional locked bursts with a hard length cap, fixed one-cycle read-data return, and sticky out-of-range detection. Port s1 stays with the Nios processor and is outside this block.

## Interface
Parameters:
- ADDR_W, 13, word address width on the masters and the memory.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MEM_WORDS, 8000, number of valid words; addresses >= MEM_WORDS are out of range.
- MAX_LOCK, 16, maximum number of consecutive locked grants to one master.

Ports:
- clk  in  1  single clock for all logic; the memory s2 side uses the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- mN_address  in  ADDR_W  word address (N = 0, 1).
- mN_byteenable  in  DATA_W/8  byte lanes for writes.
- mN_read  in  1  read request.
- mN_write  in  1  write request.
- mN_writedata  in  DATA_W  write data.
- mN_lock  in  1  keep the grant after this transfer.
- mN_waitrequest  out  1  request not accepted this cycle.
- mN_readdata  out  DATA_W  read data; qualified by readdatavalid.
- mN_readdatavalid  out  1  one-cycle pulse with the read data.
- mem_address  out  ADDR_W  to memory address2.
- mem_byteenable  out  DATA_W/8  to memory byteenable2.
- mem_chipselect  out  1  to memory chipselect2.
- mem_write  out  1  to memory write2.
- mem_writedata  out  DATA_W  to memory writedata2.
- mem_readdata  in  DATA_W  from memory readdata2; valid one cycle after the read is issued.
- oob_err  out  2  sticky per-master out-of-range flag; bit N belongs to mN.

## Operation
- Request: reqN = mN_read | mN_write. If mN_read and mN_write are both high, the write wins and the read is dropped.
- Registered state:
  - last (1 bit, reset 1): the master granted most recently.
  - owner: NONE / M0 / M1 (reset NONE).
  - lock_cnt: $clog2(MAX_LOCK+1) bits, reset 0.
  - rd_pend[1:0]: read pending per master, reset 0.
  - oob_pend[1:0]: pending read was out of range, reset 0.
  - oob_err[1:0]: sticky error flags, reset 0.
- Grant is combinational and takes effect in the same cycle, in this priority:
  - owner = Mk and reqk: grant k.
  - Only one master requesting: grant that master.
  - Both requesting: grant ~last.
  - Neither requesting: no grant.
- With owner = Mk, the other master waits (waitrequest=1) even while k is idle.
- mN_waitrequest = reqN & ~grantN. A transfer is accepted on any clock edge where reqN=1 and waitrequest=0.
- On a granted cycle the memory outputs follow mux(grant). mem_chipselect=1 and mem_write=write only when the address is in range.
- On a granted cycle with an out-of-range address:
  - no memory access;
  - oob_err[N] is set and stays set until reset;
  - a read still returns readdatavalid, with readdata = 0.
- No grant: mem_chipselect=0, mem_write=0. The other memory outputs hold the m0 values, which are don't-care.
- Lock state machine, evaluated at each accepted transfer by k:
  - mk_lock=1 and lock_cnt+1 < MAX_LOCK: owner<=Mk, lock_cnt<=lock_cnt+1.
  - Otherwise: owner<=NONE, lock_cnt<=0. This is a forced release when the cap is hit.
  - last<=k on every accepted transfer.
- Fairness after a forced release: the other master, if requesting, wins the next cycle because last=k.
- Read return: rd_pend[N] <= accepted read by N. mN_readdatavalid = rd_pend[N]. mN_readdata = oob_pend[N] ? 0 : mem_readdata.
- Back-to-back accepted reads by the same master, or alternating between masters, are permitted on every cycle.

## Timing
- Arbitration to command: 0 cycles. The memory samples the command on the same edge that accepts it.
- Read latency: exactly 1 cycle. readdatavalid is high in the cycle after acceptance.
- Write: completes at the accepting edge; no response.
- Throughput: one transfer per cycle total, across both masters.
- While reset_n=0:
  - all registers hold their reset values;
  - mem_chipselect=0, mem_write=0;
  - mN_waitrequest = reqN;
  - readdatavalid=0, oob_err=0.
- Reset asserted mid-burst: owner, lock_cnt and pending reads are discarded. No readdatavalid is issued for reads accepted before reset.
- Reset release: the first tie goes to m0.

## Test plan
- Reset with both masters reading: waitrequest=1 for both and chipselect=0. After release, m0 is granted first, then m1; m1's readdata equals mem[addr] one cycle after its acceptance.
- Continuous reads from both masters with lock=0: grants alternate m0,m1,m0,…; each master's readdatavalid pulses every other cycle.
- m0 locks over addresses 0..19 while m1 requests continuously: m0 gets exactly 16 consecutive grants (addresses 0..15), m1 gets the next cycle, then m0 resumes at address 16.
- m1 writes 0xA5A5A5A5 with byteenable=4'b0011 to address 100 over old data 0x12345678, then reads it back: returns 0x1234A5A5.
- m0 reads address 8000, then writes address 8191: chipselect stays 0; the read returns readdatavalid with 0; oob_err=2'b01 stays set until reset.
- reset_n pulled low the cycle after an accepted m1 read: m1_readdatavalid stays 0 and owner returns to NONE.

Source files
------------

// File: rtl/sys_mem_s2_arbiter.sv
// Two-master round-robin arbiter for port s2 of the system memory.
// Supports capped locked bursts, a fixed one-cycle read return and sticky out-of-range flags.
module sys_mem_s2_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 8000,
    parameter int MAX_LOCK  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_lock,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_lock,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic [1:0]            oob_err,
    output logic [1:0]            owner_state
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_CAP    = CNT_W'(MAX_LOCK - 1);
    localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t            owner, owner_nxt;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic              last, last_nxt;
    logic [1:0]        req, grant, rd_acc, rd_pend, oob_pend;
    logic              sel, accept, in_range, sel_write, sel_lock;
    logic [ADDR_W-1:0] sel_addr;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    // An owner keeps the port even while idle; otherwise ties go to the master not served last.
    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            case (owner)
                OWN_M0:  grant[0] = req[0];
                OWN_M1:  grant[1] = req[1];
                default: grant = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
            endcase
        end
    end

    assign sel       = grant[1];
    assign accept    = |grant;
    assign sel_addr  = sel ? m1_address : m0_address;
    assign sel_write = sel ? m1_write : m0_write;
    assign sel_lock  = sel ? m1_lock : m0_lock;
    assign in_range  = {1'b0, sel_addr} < ADDR_LIMIT;

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = sel ? m1_writedata : m0_writedata;
    assign mem_chipselect = accept & in_range;
    assign mem_write      = accept & in_range & sel_write;

    assign m0_waitrequest = req[0] & ~grant[0];
    assign m1_waitrequest = req[1] & ~grant[1];

    // A write on the same cycle as a read wins, so the read never returns data.
    assign rd_acc = grant & {m1_read & ~m1_write, m0_read & ~m0_write};

    always_comb begin
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        last_nxt     = last;
        if (accept) begin
            last_nxt = sel;
            if (sel_lock && (lock_cnt < CNT_CAP)) begin
                owner_nxt    = sel ? OWN_M1 : OWN_M0;
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end else begin
                owner_nxt    = OWN_NONE;
                lock_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner    <= OWN_NONE;
            lock_cnt <= '0;
            last     <= 1'b1;
            rd_pend  <= 2'b00;
            oob_pend <= 2'b00;
            oob_err  <= 2'b00;
        end else begin
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
            last     <= last_nxt;
            rd_pend  <= rd_acc;
            oob_pend <= rd_acc & {2{~in_range}};
            oob_err  <= oob_err | (grant & {2{~in_range}});
        end
    end

    assign m0_readdatavalid = rd_pend[0];
    assign m1_readdatavalid = rd_pend[1];
    assign m0_readdata      = oob_pend[0] ? '0 : mem_readdata;
    assign m1_readdata      = oob_pend[1] ? '0 : mem_readdata;
    assign owner_state      = owner;

endmodule

// File: tb/tb_sys_mem_s2_arbiter.sv
// Bench for sys_mem_s2_arbiter: behavioural s2 memory, directed cycle vectors,
// and a read-data scoreboard drained by an independent monitor.
module tb_sys_mem_s2_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic [1:0]  oob_err, owner_state;

    logic [31:0] mem [0:7999];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sys_mem_s2_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .oob_err(oob_err), .owner_state(owner_state)
    );

    function automatic logic [31:0] pat(input logic [12:0] a);
        return 32'hD00D_0000 | {19'd0, a};
    endfunction

    initial begin
        for (int i = 0; i < 8000; i++) mem[i] = pat(13'(i));
        mem[100] = 32'h1234_5678;
    end

    // Synchronous memory: readdata valid one cycle after a read command.
    always @(posedge clk) begin
        if (mem_chipselect && mem_address < 13'd8000) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every readdatavalid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (m0_readdatavalid) begin
            if (exp_q0.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL m0 unexpected readdatavalid: got data %h expected no pulse", m0_readdata);
            end else check("m0 readdata", m0_readdata, exp_q0.pop_front());
        end
        if (m1_readdatavalid) begin
            if (exp_q1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL m1 unexpected readdatavalid: got data %h expected no pulse", m1_readdata);
            end else check("m1 readdata", m1_readdata, exp_q1.pop_front());
        end
    end

    task automatic drive(input int n, input bit rd, input bit wr, input bit lk,
                         input logic [12:0] a, input logic [31:0] wd, input logic [3:0] be);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_lock = lk; m0_address = a;
            m0_writedata = wd; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_lock = lk; m1_address = a;
            m1_writedata = wd; m1_byteenable = be;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 0, 13'd0, 32'd0, 4'h0);
        drive(1, 0, 0, 0, 13'd0, 32'd0, 4'h0);
    endtask

    // One bus cycle; g is the master expected to be granted (-1: none).
    task automatic step(input int g, input logic [31:0] exp_data, input bit push, input string tag);
        logic r0, r1, wr_g, rd_g, inr;
        logic [12:0] a_g;
        @(negedge clk);
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        check({tag, " m0_waitrequest"}, 32'(m0_waitrequest), 32'(r0 && g != 0));
        check({tag, " m1_waitrequest"}, 32'(m1_waitrequest), 32'(r1 && g != 1));
        if (g >= 0) begin
            a_g  = (g == 1) ? m1_address : m0_address;
            wr_g = (g == 1) ? m1_write : m0_write;
            rd_g = ((g == 1) ? m1_read : m0_read) & ~wr_g;
            inr  = a_g < 13'd8000;
            check({tag, " chipselect"}, 32'(mem_chipselect), 32'(inr));
            check({tag, " mem_write"}, 32'(mem_write), 32'(inr & wr_g));
            if (inr) check({tag, " mem_address"}, 32'(mem_address), 32'(a_g));
            if (rd_g && push) begin
                if (g == 1) exp_q1.push_back(exp_data);
                else exp_q0.push_back(exp_data);
            end
        end else begin
            check({tag, " chipselect idle"}, 32'(mem_chipselect), 32'd0);
            check({tag, " mem_write idle"}, 32'(mem_write), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [12:0] a0, a1;
        int g;
        reset_n = 1'b0;
        idle_all();
        drive(0, 1, 0, 0, 13'd10, 32'd0, 4'hF);
        drive(1, 1, 0, 0, 13'd20, 32'd0, 4'hF);
        step(-1, 32'd0, 0, "reset");
        step(-1, 32'd0, 0, "reset");
        check("reset owner", 32'(owner_state), 32'd0);
        check("reset oob_err", 32'(oob_err), 32'd0);
        check("reset rdvalid", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
        reset_n = 1'b1;

        // Both masters reading without lock: strict alternation starting with m0.
        a0 = 13'd10; a1 = 13'd20;
        for (int i = 0; i < 8; i++) begin
            g = i % 2;
            drive(0, 1, 0, 0, a0, 32'd0, 4'hF);
            drive(1, 1, 0, 0, a1, 32'd0, 4'hF);
            step(g, (g == 1) ? pat(a1) : pat(a0), 1, "alt");
            check("alt m0 rdvalid", 32'(m0_readdatavalid), 32'(g == 0));
            check("alt m1 rdvalid", 32'(m1_readdatavalid), 32'(g == 1));
            if (g == 1) a1++; else a0++;
        end
        idle_all();

        // m0 locked burst over 0..19 against continuous m1 reads at 200.
        a0 = 13'd0;
        for (int c = 0; c < 22; c++) begin
            g = (c < 16) ? 0 : (c == 16) ? 1 : (c <= 20) ? 0 : 1;
            drive(0, a0 < 13'd20, 0, a0 != 13'd19, a0, 32'd0, 4'hF);
            drive(1, 1, 0, 0, 13'd200, 32'd0, 4'hF);
            step(g, (g == 1) ? pat(13'd200) : pat(a0), 1, "lock");
            if (c == 5) check("lock owner m0", 32'(owner_state), 32'd1);
            if (g == 0) a0++;
        end
        idle_all();
        check("burst released", 32'(owner_state), 32'd0);

        // Partial-byte write then readback.
        drive(1, 0, 1, 0, 13'd100, 32'hA5A5_A5A5, 4'b0011);
        step(1, 32'd0, 0, "be write");
        drive(1, 1, 0, 0, 13'd100, 32'd0, 4'hF);
        step(1, 32'h1234_A5A5, 1, "be readback");
        idle_all();
        step(-1, 32'd0, 0, "gap");

        // Out-of-range read and write by m0.
        drive(0, 1, 0, 0, 13'd8000, 32'd0, 4'hF);
        step(0, 32'd0, 1, "oob read");
        check("oob_err after read", 32'(oob_err), 32'd1);
        drive(0, 0, 1, 0, 13'd8191, 32'hFFFF_FFFF, 4'hF);
        step(0, 32'd0, 0, "oob write");
        check("oob_err after write", 32'(oob_err), 32'd1);
        drive(0, 1, 0, 0, 13'd5, 32'd0, 4'hF);
        step(0, pat(13'd5), 1, "read after oob");
        idle_all();
        step(-1, 32'd0, 0, "gap");
        check("oob_err sticky", 32'(oob_err), 32'd1);

        // Reset right after an accepted locked m1 read discards it.
        drive(1, 1, 0, 1, 13'd30, 32'd0, 4'hF);
        step(1, 32'd0, 0, "pre-reset read");
        check("owner m1 before reset", 32'(owner_state), 32'd2);
        reset_n = 1'b0;
        idle_all();
        #1;
        check("mid reset owner", 32'(owner_state), 32'd0);
        check("mid reset m1 rdvalid", 32'(m1_readdatavalid), 32'd0);
        check("mid reset oob_err", 32'(oob_err), 32'd0);
        step(-1, 32'd0, 0, "held reset");
        reset_n = 1'b1;
        drive(0, 1, 0, 0, 13'd40, 32'd0, 4'hF);
        drive(1, 1, 0, 0, 13'd50, 32'd0, 4'hF);
        step(0, pat(13'd40), 1, "tie after reset");
        step(1, pat(13'd50), 1, "second after reset");
        idle_all();
        step(-1, 32'd0, 0, "drain");
        step(-1, 32'd0, 0, "drain");

        check("m0 pending reads left", 32'(exp_q0.size()), 32'd0);
        check("m1 pending reads left", 32'(exp_q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
